// File: rtl/keypad_symbol_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared definitions for the keypad symbol encoder.
//               Holds the symbol codes, the encoder FSM state encodings,
//               the debounce counter sizing helper and the one-hot to
//               symbol encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  // Symbol codes emitted for each button
  localparam logic [1:0] SYM_I1 = 2'b00;
  localparam logic [1:0] SYM_I2 = 2'b01;
  localparam logic [1:0] SYM_I3 = 2'b10;
  localparam logic [1:0] SYM_I4 = 2'b11;

  // Encoder FSM state encodings
  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_HELD  = 2'd1;
  localparam state_t ST_CHORD = 2'd2;

  // The counter must be able to hold DEBOUNCE_CYCLES itself
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  // Maps a one-hot button vector {i4,i3,i2,i1} to its symbol code
  function automatic logic [1:0] sym_encode(input logic [3:0] lvl);
    logic [1:0] code;
    case (lvl)
      4'b0001: code = SYM_I1;
      4'b0010: code = SYM_I2;
      4'b0100: code = SYM_I3;
      4'b1000: code = SYM_I4;
      default: code = SYM_I1;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_symbol_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_symbol_encoder_if
// Description : Output bundle from the keypad encoder to the lock stage.
//               master : encoder side (drives everything)
//               slave  : lock-core side (consumes everything)
//   sym[1:0]   symbol code, valid while sym_valid is high
//   sym_valid  one-cycle symbol strobe
//   sym_idx    index of the next symbol to be emitted
//   frame_done one-cycle pulse with the last symbol of a code
//   re_pulse   one-cycle pulse on a debounced press of re
//   multi_err  one-cycle pulse when a chord is detected
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_symbol_encoder_if;
  logic [1:0] sym;
  logic       sym_valid;
  logic [2:0] sym_idx;
  logic       frame_done;
  logic       re_pulse;
  logic       multi_err;

  modport master (
    output sym, sym_valid, sym_idx, frame_done, re_pulse, multi_err
  );

  modport slave (
    input  sym, sym_valid, sym_idx, frame_done, re_pulse, multi_err
  );
endinterface
`default_nettype wire

// File: rtl/keypad_symbol_encoder_kp_debounce.sv
`default_nettype none
// ============================================================================
// Module      : kp_debounce
// Description : One debounce channel. The level flips only after the input
//               has differed from it for DEBOUNCE_CYCLES consecutive samples.
//               Optional macro KEYPAD_SYNC_EN inserts a 2-flop synchronizer
//               in front of the counter (2 extra cycles of latency).
//   clk   system clock
//   clr   synchronous active-low reset
//   raw   bouncy input
//   level debounced level
// Revision    : 1.0 - initial release
// ============================================================================
module kp_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic clr,
  input  wire logic raw,
  output logic      level
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic w_sample;

`ifdef KEYPAD_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!clr) r_sync <= '0;
    else      r_sync <= {r_sync[0], raw};
  end

  assign w_sample = r_sync[1];
`else
  assign w_sample = raw;
`endif

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // The sample that makes the run DEBOUNCE_CYCLES long flips the level directly
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sample != r_level) begin
      if (r_cnt == C_CNT_LAST) begin
        r_level <= w_sample;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/keypad_symbol_encoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_symbol_encoder
// Description : Keypad front end for the combination lock. Debounces
//               i1..i4 and re, emits one symbol per clean single press,
//               flags chords, tracks the symbol index within a code frame.
//               Optional macro KEYPAD_SYNC_EN: 2-flop input synchronizers.
//   clk        system clock
//   clr        synchronous active-low reset
//   i1..i4     raw buttons, active-high
//   re         raw reprogram button, active-high
//   bus        keypad_symbol_encoder_if.master output bundle
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_symbol_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYMS_PER_CODE   = 4
) (
  input  wire logic clk,
  input  wire logic clr,
  input  wire logic i1,
  input  wire logic i2,
  input  wire logic i3,
  input  wire logic i4,
  input  wire logic re,
  keypad_symbol_encoder_if.master bus
);

  localparam logic [2:0] C_IDX_LAST = 3'(SYMS_PER_CODE - 1);

  // Channel order: {re, i4, i3, i2, i1}
  logic [4:0] w_raw;
  logic [4:0] w_lvl;

  assign w_raw = {re, i4, i3, i2, i1};

  for (genvar g = 0; g < 5; g++) begin : g_chan
    kp_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .clr  (clr),
      .raw  (w_raw[g]),
      .level(w_lvl[g])
    );
  end

  logic [3:0] w_btn;
  logic       w_none;
  logic       w_one;
  logic       w_many;

  assign w_btn  = w_lvl[3:0];
  assign w_none = (w_btn == 4'b0000);
  assign w_one  = $onehot(w_btn);
  assign w_many = !w_none && !w_one;

  // ---------------- encoder FSM ----------------
  state_t r_state;
  state_t w_state_nxt;
  logic   w_strobe;
  logic   w_chord;

  always_ff @(posedge clk) begin
    if (!clr) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_one)       w_state_nxt = ST_HELD;
        else if (w_many) w_state_nxt = ST_CHORD;
      end
      ST_HELD: begin
        if (w_many)      w_state_nxt = ST_CHORD;
        else if (w_none) w_state_nxt = ST_IDLE;
      end
      ST_CHORD: begin
        if (w_none)      w_state_nxt = ST_IDLE;
      end
      default:           w_state_nxt = ST_IDLE;
    endcase
  end

  // A strobe only ever leaves IDLE, so holding a button cannot repeat it
  always_comb begin
    w_strobe = 1'b0;
    w_chord  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_strobe = w_one;
        w_chord  = w_many;
      end
      ST_HELD: begin
        w_chord  = w_many;
      end
      default: begin
        w_strobe = 1'b0;
        w_chord  = 1'b0;
      end
    endcase
  end

  // ---------------- registered outputs ----------------
  logic       r_re_prev;
  logic       w_re_rise;
  logic [1:0] r_sym;
  logic       r_sym_valid;
  logic [2:0] r_idx;
  logic       r_frame_done;
  logic       r_re_pulse;
  logic       r_multi_err;

  assign w_re_rise = w_lvl[4] && !r_re_prev;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_re_prev    <= 1'b0;
      r_sym        <= 2'b00;
      r_sym_valid  <= 1'b0;
      r_idx        <= 3'd0;
      r_frame_done <= 1'b0;
      r_re_pulse   <= 1'b0;
      r_multi_err  <= 1'b0;
    end else begin
      r_re_prev    <= w_lvl[4];
      r_sym_valid  <= w_strobe;
      r_multi_err  <= w_chord;
      r_re_pulse   <= w_re_rise;
      // Frame end is judged on the index the symbol is emitted with
      r_frame_done <= w_strobe && (r_idx == C_IDX_LAST);
      if (w_strobe) r_sym <= sym_encode(w_btn);
      // A reprogram press wins over a coincident symbol's increment
      if (w_re_rise) begin
        r_idx <= 3'd0;
      end else if (w_strobe) begin
        r_idx <= (r_idx == C_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end
    end
  end

  assign bus.sym        = r_sym;
  assign bus.sym_valid  = r_sym_valid;
  assign bus.sym_idx    = r_idx;
  assign bus.frame_done = r_frame_done;
  assign bus.re_pulse   = r_re_pulse;
  assign bus.multi_err  = r_multi_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_symbol_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_symbol_encoder
// Description : Self-checking bench for keypad_symbol_encoder
//               (DEBOUNCE_CYCLES=4, SYMS_PER_CODE=4, synchronizers off).
//               Directed scenarios plus random button traffic, all compared
//               each cycle against a behavioural model of the keypad rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_symbol_encoder;

  localparam int DB  = 4;
  localparam int SPC = 4;

  localparam bit [4:0] B1 = 5'b00001;
  localparam bit [4:0] B2 = 5'b00010;
  localparam bit [4:0] B3 = 5'b00100;
  localparam bit [4:0] B4 = 5'b01000;
  localparam bit [4:0] BR = 5'b10000;

  logic clk = 1'b0;
  logic clr, i1, i2, i3, i4, re;

  keypad_symbol_encoder_if kp_if();

  keypad_symbol_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .SYMS_PER_CODE  (SPC)
  ) dut (
    .clk(clk),
    .clr(clr),
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .i4 (i4),
    .re (re),
    .bus(kp_if.master)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  // Each channel keeps its last DB raw samples; the level flips once all of
  // them disagree with it. Buttons: a symbol needs a single button with no
  // other press since the last full release; a chord is reported once.
  bit          m_lvl  [5];
  bit [DB-1:0] m_win  [5];
  int          m_fill [5];
  bit          m_busy, m_chord, m_re_prev;
  int          m_idx;
  bit [1:0]    m_sym;
  bit          e_valid, e_multi, e_frame, e_re;
  bit          exp_known = 1'b0;

  task automatic model_step(input bit [4:0] raw, input bit c);
    int n;
    if (!c) begin
      for (int k = 0; k < 5; k++) begin
        m_lvl[k] = 1'b0; m_win[k] = '0; m_fill[k] = 0;
      end
      m_busy = 0; m_chord = 0; m_re_prev = 0; m_idx = 0; m_sym = 2'b00;
      e_valid = 0; e_multi = 0; e_frame = 0; e_re = 0;
    end else begin
      n = 0;
      for (int k = 0; k < 4; k++) n += int'(m_lvl[k]);
      e_valid = (n == 1) && !m_busy;
      e_multi = (n >= 2) && !m_chord;
      e_frame = e_valid && (m_idx == SPC - 1);
      if (e_valid)
        for (int k = 0; k < 4; k++) if (m_lvl[k]) m_sym = 2'(k);
      e_re = m_lvl[4] && !m_re_prev;
      m_re_prev = m_lvl[4];
      if (e_re)         m_idx = 0;
      else if (e_valid) m_idx = (m_idx + 1) % SPC;
      if (n == 0) begin
        m_busy = 0; m_chord = 0;
      end else begin
        m_busy = 1;
        if (n >= 2) m_chord = 1;
      end
      for (int k = 0; k < 5; k++) begin
        m_win[k] = {m_win[k][DB-2:0], raw[k]};
        if (m_fill[k] < DB) m_fill[k]++;
        if (m_fill[k] >= DB && m_win[k] == (m_lvl[k] ? {DB{1'b0}} : {DB{1'b1}}))
          m_lvl[k] = ~m_lvl[k];
      end
    end
  endtask

  // ---------------- observation of DUT events ----------------
  int       cyc_n = 0;
  int       n_valid, n_multi, n_frame, n_re, last_strobe_cyc, frame_at;
  logic [1:0] last_sym;
  logic [7:0] sym_hist;

  task automatic clear_obs();
    n_valid = 0; n_multi = 0; n_frame = 0; n_re = 0;
    last_strobe_cyc = -1; frame_at = -1; last_sym = 2'b00; sym_hist = 8'h00;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // One clock: compare at the falling edge, then drive and advance the model
  task automatic cyc(input bit [4:0] raw, input bit c);
    @(negedge clk);
    if (exp_known) begin
      chk("sym_valid",  8'(kp_if.sym_valid),  8'(e_valid));
      chk("sym",        8'(kp_if.sym),        8'(m_sym));
      chk("sym_idx",    8'(kp_if.sym_idx),    8'(m_idx));
      chk("frame_done", 8'(kp_if.frame_done), 8'(e_frame));
      chk("re_pulse",   8'(kp_if.re_pulse),   8'(e_re));
      chk("multi_err",  8'(kp_if.multi_err),  8'(e_multi));
      if (kp_if.sym_valid === 1'b1) begin
        n_valid++;
        last_sym        = kp_if.sym;
        sym_hist        = {sym_hist[5:0], kp_if.sym};
        last_strobe_cyc = cyc_n;
      end
      if (kp_if.frame_done === 1'b1) begin n_frame++; frame_at = n_valid; end
      if (kp_if.multi_err  === 1'b1) n_multi++;
      if (kp_if.re_pulse   === 1'b1) n_re++;
    end
    cyc_n++;
    {re, i4, i3, i2, i1} = raw;
    clr = c;
    model_step(raw, c);
    exp_known = 1'b1;
  endtask

  task automatic hold(input bit [4:0] raw, input int n);
    for (int k = 0; k < n; k++) cyc(raw, 1'b1);
  endtask

  task automatic do_reset();
    cyc(5'b0, 1'b0);
    cyc(5'b0, 1'b0);
    hold(5'b0, 1);
    clear_obs();
  endtask

  int p;
  int len, kind, a, b;
  bit [4:0] pat, r;
  bit       c;

  initial begin
    clr = 1'b0; i1 = 0; i2 = 0; i3 = 0; i4 = 0; re = 0;
    clear_obs();

    // 1: clean i3 press
    do_reset();
    chk("rst_sym", 8'(kp_if.sym), 8'h00);
    chk("rst_idx", 8'(kp_if.sym_idx), 8'h00);
    hold(B3, 1); p = cyc_n;
    hold(B3, 9); hold(5'b0, 8);
    chk("t1_count",   8'(n_valid), 8'd1);
    chk("t1_sym",     8'(last_sym), 8'h2);
    chk("t1_latency", 8'(last_strobe_cyc - p), 8'd4);
    chk("t1_idx",     8'(kp_if.sym_idx), 8'd1);
    chk("t1_multi",   8'(n_multi), 8'd0);

    // 2: bouncing i2 never settles
    do_reset();
    for (int k = 0; k < 12; k++) hold((k % 2 == 0) ? B2 : 5'b0, 1);
    hold(5'b0, 8);
    chk("t2_count", 8'(n_valid), 8'd0);
    chk("t2_multi", 8'(n_multi), 8'd0);

    // 3: a full frame i1..i4
    do_reset();
    hold(B1, 6); hold(5'b0, 6);
    hold(B2, 6); hold(5'b0, 6);
    hold(B3, 6); hold(5'b0, 6);
    hold(B4, 6); hold(5'b0, 6);
    hold(5'b0, 4);
    chk("t3_count",    8'(n_valid), 8'd4);
    chk("t3_syms",     sym_hist, 8'h1B);
    chk("t3_frames",   8'(n_frame), 8'd1);
    chk("t3_frame_at", 8'(frame_at), 8'd4);
    chk("t3_idx",      8'(kp_if.sym_idx), 8'd0);

    // 4: simultaneous chord, then a clean press
    do_reset();
    hold(B1 | B4, 8); hold(5'b0, 8);
    chk("t4_multi", 8'(n_multi), 8'd1);
    chk("t4_count", 8'(n_valid), 8'd0);
    clear_obs();
    hold(B2, 6); hold(5'b0, 8);
    chk("t4_next_count", 8'(n_valid), 8'd1);
    chk("t4_next_sym",   8'(last_sym), 8'h1);

    // 5: second button joins a held one
    do_reset();
    hold(B1, 6); hold(B1 | B2, 8); hold(5'b0, 8);
    chk("t5_count", 8'(n_valid), 8'd1);
    chk("t5_sym",   8'(last_sym), 8'h0);
    chk("t5_multi", 8'(n_multi), 8'd1);
    chk("t5_idx",   8'(kp_if.sym_idx), 8'd1);

    // 6: reprogram clears the index; reset during a debounce
    do_reset();
    hold(B1, 6); hold(5'b0, 6);
    hold(B2, 6); hold(5'b0, 6);
    chk("t6_idx_before", 8'(kp_if.sym_idx), 8'd2);
    hold(BR, 6); hold(5'b0, 8);
    chk("t6_re_count",  8'(n_re), 8'd1);
    chk("t6_idx_after", 8'(kp_if.sym_idx), 8'd0);
    clear_obs();
    hold(B4, 2); cyc(B4, 1'b0);
    hold(B4, 1); p = cyc_n;
    hold(B4, 9); hold(5'b0, 8);
    chk("t6_clr_count",   8'(n_valid), 8'd1);
    chk("t6_clr_sym",     8'(last_sym), 8'h3);
    chk("t6_clr_latency", 8'(last_strobe_cyc - p), 8'd4);

    // Random traffic: presses, chords, re, noise and occasional resets
    for (int s = 0; s < 350; s++) begin
      len  = $urandom_range(1, 12);
      kind = $urandom_range(0, 9);
      a    = $urandom_range(0, 3);
      b    = $urandom_range(0, 3);
      case (kind)
        0, 1, 2:    pat = 5'b0;
        3, 4, 5, 6: pat = 5'(1 << a);
        7:          pat = 5'((1 << a) | (1 << b));
        8:          pat = BR | 5'($urandom_range(0, 1) << a);
        default:    pat = 5'b0;
      endcase
      for (int k = 0; k < len; k++) begin
        r = (kind == 9) ? 5'($urandom) : pat;
        c = ($urandom_range(0, 99) != 0);
        cyc(r, c);
      end
    end
    hold(5'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
